// File: rtl/avalon_burst_arbiter.sv
// Avalon-MM burst arbiter: N masters share one slave port. Writes hold the
// grant for the whole burst; reads release it once the command is accepted,
// and a tracker FIFO routes returning read beats back to the issuing master.
module avalon_burst_arbiter #(
    parameter int NumMasters    = 4,
    parameter int DataWidth     = 256,
    parameter int AddressWidth  = 27,
    parameter int BurstWidth    = 8,
    parameter int PendingDepth  = 8,
    parameter int FixedPriority = 0
) (
    input  logic                                  ipClk,
    input  logic                                  ipReset,
    input  logic [NumMasters*AddressWidth-1:0]    ipMaster_Address,
    input  logic [NumMasters*DataWidth/8-1:0]     ipMaster_ByteEnable,
    input  logic [NumMasters*BurstWidth-1:0]      ipMaster_BurstCount,
    input  logic [NumMasters*DataWidth-1:0]       ipMaster_WriteData,
    input  logic [NumMasters-1:0]                 ipMaster_Write,
    input  logic [NumMasters-1:0]                 ipMaster_Read,
    output logic [NumMasters-1:0]                 opMaster_WaitRequest,
    output logic [DataWidth-1:0]                  opMaster_ReadData,
    output logic [NumMasters-1:0]                 opMaster_ReadValid,
    input  logic                                  ipAvalon_WaitRequest,
    output logic [AddressWidth-1:0]               opAvalon_Address,
    output logic [DataWidth/8-1:0]                opAvalon_ByteEnable,
    output logic [BurstWidth-1:0]                 opAvalon_BurstCount,
    output logic [DataWidth-1:0]                  opAvalon_WriteData,
    output logic                                  opAvalon_Write,
    output logic                                  opAvalon_Read,
    input  logic [DataWidth-1:0]                  ipAvalon_ReadData,
    input  logic                                  ipAvalon_ReadValid,
    output logic [$clog2(PendingDepth+1)-1:0]     opPendingReads,
    output logic                                  opError
);
    localparam int IdxW = $clog2(NumMasters);
    localparam int PtrW = (PendingDepth > 1) ? $clog2(PendingDepth) : 1;
    localparam int CntW = $clog2(PendingDepth + 1);
    localparam int BeW  = DataWidth / 8;

    typedef enum logic [1:0] {IDLE, WRITE_BURST, READ_CMD} state_e;

    state_e               state_q, state_d;
    logic [IdxW-1:0]      grant_q, grant_d;
    logic [IdxW-1:0]      last_q, last_d;
    logic [BurstWidth-1:0] beat_cnt_q, beat_cnt_d;
    logic                 started_q, started_d;

    logic [IdxW-1:0]       fifo_idx_q [PendingDepth];
    logic [IdxW-1:0]       fifo_idx_d [PendingDepth];
    logic [BurstWidth-1:0] fifo_len_q [PendingDepth];
    logic [BurstWidth-1:0] fifo_len_d [PendingDepth];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [BurstWidth-1:0] rem_q, rem_d;
    logic [NumMasters-1:0] rvalid_q, rvalid_d;
    logic [DataWidth-1:0]  rdata_q, rdata_d;
    logic                  error_q, error_d;

    logic [AddressWidth-1:0] m_addr [NumMasters];
    logic [BeW-1:0]          m_be   [NumMasters];
    logic [BurstWidth-1:0]   m_bc   [NumMasters];
    logic [DataWidth-1:0]    m_wd   [NumMasters];
    logic [BurstWidth-1:0]   g_bc, head_left;
    logic                    g_write, g_read, full, push, pop, win_found;
    logic [IdxW-1:0]         win_idx;
    logic [NumMasters-1:0]   req;

    // Unpack the flat per-master buses into arrays indexed by master
    always_comb begin
        for (int unsigned i = 0; i < NumMasters; i++) begin
            m_addr[i] = ipMaster_Address[i*AddressWidth +: AddressWidth];
            m_be[i]   = ipMaster_ByteEnable[i*BeW +: BeW];
            m_bc[i]   = ipMaster_BurstCount[i*BurstWidth +: BurstWidth];
            m_wd[i]   = ipMaster_WriteData[i*DataWidth +: DataWidth];
        end
    end

    assign g_bc    = m_bc[grant_q];
    assign g_write = ipMaster_Write[grant_q];
    assign g_read  = ipMaster_Read[grant_q];
    assign full    = (count_q == CntW'(PendingDepth));

    // Pick the next master: nearest requester after last grant, or lowest index
    always_comb begin
        req       = ipMaster_Write | ipMaster_Read;
        win_found = 1'b0;
        win_idx   = '0;
        if (FixedPriority != 0) begin
            // Descending scan so the lowest requesting index is written last
            for (int unsigned i = NumMasters; i > 0; i--) begin
                if (req[i-1]) begin
                    win_found = 1'b1;
                    win_idx   = IdxW'(i - 1);
                end
            end
        end else begin
            // Descending offset scan so the offset closest to last+1 wins
            for (int unsigned k = NumMasters; k > 0; k--) begin
                if (req[(32'(last_q) + k) % NumMasters]) begin
                    win_found = 1'b1;
                    win_idx   = IdxW'((32'(last_q) + k) % NumMasters);
                end
            end
        end
    end

    // Grant FSM: next state, burst beat counting and slave-port muxing
    always_comb begin
        state_d              = state_q;
        grant_d              = grant_q;
        last_d               = last_q;
        beat_cnt_d           = beat_cnt_q;
        started_d            = started_q;
        push                 = 1'b0;
        opAvalon_Write       = 1'b0;
        opAvalon_Read        = 1'b0;
        opMaster_WaitRequest = '1;
        opAvalon_Address     = m_addr[grant_q];
        opAvalon_ByteEnable  = m_be[grant_q];
        opAvalon_BurstCount  = g_bc;
        opAvalon_WriteData   = m_wd[grant_q];
        case (state_q)
            IDLE: begin
                started_d = 1'b0;
                if (win_found) begin
                    grant_d = win_idx;
                    last_d  = win_idx;
                    state_d = ipMaster_Write[win_idx] ? WRITE_BURST : READ_CMD;
                end
            end
            WRITE_BURST: begin
                opAvalon_Write                = g_write;
                opMaster_WaitRequest[grant_q] = ipAvalon_WaitRequest;
                if (g_write && !ipAvalon_WaitRequest) begin
                    if (!started_q) begin
                        if (g_bc == '0 || g_bc == BurstWidth'(1)) begin
                            state_d = IDLE;
                        end else begin
                            beat_cnt_d = g_bc - BurstWidth'(1);
                            started_d  = 1'b1;
                        end
                    end else if (beat_cnt_q == BurstWidth'(1)) begin
                        state_d   = IDLE;
                        started_d = 1'b0;
                    end else begin
                        beat_cnt_d = beat_cnt_q - BurstWidth'(1);
                    end
                end
            end
            READ_CMD: begin
                opAvalon_Read                 = g_read & ~full;
                opMaster_WaitRequest[grant_q] = ipAvalon_WaitRequest | full;
                if (!g_read) begin
                    state_d = IDLE;
                end else if (!full && !ipAvalon_WaitRequest) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read tracker: push accepted read commands, route and count returning beats
    always_comb begin
        fifo_idx_d = fifo_idx_q;
        fifo_len_d = fifo_len_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rem_d      = rem_q;
        rvalid_d   = '0;
        rdata_d    = ipAvalon_ReadData;
        error_d    = error_q;
        pop        = 1'b0;
        head_left  = '0;
        if (push) begin
            fifo_idx_d[wr_ptr_q] = grant_q;
            fifo_len_d[wr_ptr_q] = (g_bc == '0) ? BurstWidth'(1) : g_bc;
            wr_ptr_d             = wr_ptr_q + PtrW'(1);
        end
        if (ipAvalon_ReadValid) begin
            if (count_q == '0) begin
                error_d = 1'b1;
            end else begin
                rvalid_d[fifo_idx_q[rd_ptr_q]] = 1'b1;
                // rem of zero means the head burst has not started returning yet
                head_left = (rem_q == '0) ? fifo_len_q[rd_ptr_q] : rem_q;
                if (head_left == BurstWidth'(1)) begin
                    pop      = 1'b1;
                    rem_d    = '0;
                    rd_ptr_d = rd_ptr_q + PtrW'(1);
                end else begin
                    rem_d = head_left - BurstWidth'(1);
                end
            end
        end
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    // State, grant and tracker registers
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            last_q     <= IdxW'(NumMasters - 1);
            beat_cnt_q <= '0;
            started_q  <= 1'b0;
            for (int unsigned i = 0; i < PendingDepth; i++) begin
                fifo_idx_q[i] <= '0;
                fifo_len_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rem_q      <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
            started_q  <= started_d;
            fifo_idx_q <= fifo_idx_d;
            fifo_len_q <= fifo_len_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rem_q      <= rem_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            error_q    <= error_d;
        end
    end

    assign opMaster_ReadData  = rdata_q;
    assign opMaster_ReadValid = rvalid_q;
    assign opPendingReads     = count_q;
    assign opError            = error_q;

endmodule

// File: tb/tb_avalon_burst_arbiter.sv
// Directed bench for avalon_burst_arbiter: a round-robin instance and a
// fixed-priority instance share the same master/slave stimulus.
module tb_avalon_burst_arbiter;
    localparam int NM  = 4;
    localparam int DW  = 32;
    localparam int AW  = 27;
    localparam int BW  = 8;
    localparam int PD  = 8;
    localparam int CW  = 4;
    localparam int BEW = DW / 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NM*AW-1:0]  m_addr;
    logic [NM*BEW-1:0] m_be;
    logic [NM*BW-1:0]  m_bc;
    logic [NM*DW-1:0]  m_wd;
    logic [NM-1:0]     m_wr, m_rd;
    logic              s_wait, s_rvalid;
    logic [DW-1:0]     s_rdata;

    logic [NM-1:0]  wait_rr, rvalid_rr, wait_fp, rvalid_fp;
    logic [DW-1:0]  rdata_rr, rdata_fp, a_wd, a_wd_fp;
    logic [AW-1:0]  a_addr, a_addr_fp;
    logic [BEW-1:0] a_be, a_be_fp;
    logic [BW-1:0]  a_bc, a_bc_fp;
    logic           a_wr, a_rd, a_wr_fp, a_rd_fp, err_rr, err_fp;
    logic [CW-1:0]  pend_rr, pend_fp;

    int n_tests = 0;
    int n_fail  = 0;

    avalon_burst_arbiter #(.NumMasters(NM), .DataWidth(DW), .AddressWidth(AW),
        .BurstWidth(BW), .PendingDepth(PD), .FixedPriority(0)) dut (
        .ipClk(clk), .ipReset(rst_n),
        .ipMaster_Address(m_addr), .ipMaster_ByteEnable(m_be),
        .ipMaster_BurstCount(m_bc), .ipMaster_WriteData(m_wd),
        .ipMaster_Write(m_wr), .ipMaster_Read(m_rd),
        .opMaster_WaitRequest(wait_rr), .opMaster_ReadData(rdata_rr),
        .opMaster_ReadValid(rvalid_rr), .ipAvalon_WaitRequest(s_wait),
        .opAvalon_Address(a_addr), .opAvalon_ByteEnable(a_be),
        .opAvalon_BurstCount(a_bc), .opAvalon_WriteData(a_wd),
        .opAvalon_Write(a_wr), .opAvalon_Read(a_rd),
        .ipAvalon_ReadData(s_rdata), .ipAvalon_ReadValid(s_rvalid),
        .opPendingReads(pend_rr), .opError(err_rr));

    avalon_burst_arbiter #(.NumMasters(NM), .DataWidth(DW), .AddressWidth(AW),
        .BurstWidth(BW), .PendingDepth(PD), .FixedPriority(1)) dut_fp (
        .ipClk(clk), .ipReset(rst_n),
        .ipMaster_Address(m_addr), .ipMaster_ByteEnable(m_be),
        .ipMaster_BurstCount(m_bc), .ipMaster_WriteData(m_wd),
        .ipMaster_Write(m_wr), .ipMaster_Read(m_rd),
        .opMaster_WaitRequest(wait_fp), .opMaster_ReadData(rdata_fp),
        .opMaster_ReadValid(rvalid_fp), .ipAvalon_WaitRequest(s_wait),
        .opAvalon_Address(a_addr_fp), .opAvalon_ByteEnable(a_be_fp),
        .opAvalon_BurstCount(a_bc_fp), .opAvalon_WriteData(a_wd_fp),
        .opAvalon_Write(a_wr_fp), .opAvalon_Read(a_rd_fp),
        .ipAvalon_ReadData(s_rdata), .ipAvalon_ReadValid(s_rvalid),
        .opPendingReads(pend_fp), .opError(err_fp));

    function automatic logic [AW-1:0] addr_of(input int i);
        return AW'(32'h000A_0000 + 32'(i) * 32'h100);
    endfunction
    function automatic logic [DW-1:0] wd_of(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction
    function automatic logic [BEW-1:0] be_of(input int i);
        return BEW'(4'hF >> i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int i, input logic wr, input logic rd, input logic [BW-1:0] bc);
        m_addr[i*AW +: AW]   = addr_of(i);
        m_be[i*BEW +: BEW]   = be_of(i);
        m_wd[i*DW +: DW]     = wd_of(i);
        m_bc[i*BW +: BW]     = bc;
        m_wr[i]              = wr;
        m_rd[i]              = rd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({a_wr, a_rd, wait_rr, rvalid_rr, pend_rr, err_rr} !== {2'b00, 4'hF, 4'h0, 4'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_ctrl: wr=%b rd=%b wait=%b rv=%b pend=%0d err=%b, want 0 0 1111 0000 0 0",
                     a_wr, a_rd, wait_rr, rvalid_rr, pend_rr, err_rr);
        end
        n_tests++;
        if (rdata_rr !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h want 0", rdata_rr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_rr_write();
        set_master(0, 1'b1, 1'b0, 8'd4);
        set_master(2, 1'b1, 1'b0, 8'd4);
        n_tests++;
        if ({a_wr, wait_rr} !== {1'b0, 4'hF}) begin
            n_fail++;
            $display("FAIL rr_idle_pre: wr=%b wait=%b want 0 1111", a_wr, wait_rr);
        end
        tick();
        for (int b = 1; b <= 4; b++) begin
            n_tests++;
            if ({a_wr, wait_rr, a_addr, a_be, a_bc, a_wd} !==
                {1'b1, 4'b1110, addr_of(0), be_of(0), 8'd4, wd_of(0)}) begin
                n_fail++;
                $display("FAIL rr_m0_beat%0d: wr=%b wait=%b addr=%h be=%h bc=%0d wd=%h, want 1 1110 %h %h 4 %h",
                         b, a_wr, wait_rr, a_addr, a_be, a_bc, a_wd, addr_of(0), be_of(0), wd_of(0));
            end
            tick();
        end
        n_tests++;
        if ({a_wr, a_rd, wait_rr} !== {2'b00, 4'hF}) begin
            n_fail++;
            $display("FAIL rr_gap_idle: wr=%b rd=%b wait=%b want 0 0 1111", a_wr, a_rd, wait_rr);
        end
        tick();
        m_wr[0] = 1'b0;
        for (int b = 1; b <= 4; b++) begin
            n_tests++;
            if ({a_wr, wait_rr, a_addr, a_wd} !== {1'b1, 4'b1011, addr_of(2), wd_of(2)}) begin
                n_fail++;
                $display("FAIL rr_m2_beat%0d: wr=%b wait=%b addr=%h wd=%h, want 1 1011 %h %h",
                         b, a_wr, wait_rr, a_addr, a_wd, addr_of(2), wd_of(2));
            end
            tick();
        end
        m_wr[2] = 1'b0;
        n_tests++;
        if ({a_wr, wait_rr} !== {1'b0, 4'hF}) begin
            n_fail++;
            $display("FAIL rr_end_idle: wr=%b wait=%b want 0 1111", a_wr, wait_rr);
        end
    endtask

    task automatic test_write_stall_hold();
        // last grant is 2: master 3 writes a zero-length burst through a stall
        s_wait = 1'b1;
        set_master(3, 1'b1, 1'b0, 8'd0);
        tick();
        tick();
        n_tests++;
        if ({a_wr, wait_rr, a_addr} !== {1'b1, 4'hF, addr_of(3)}) begin
            n_fail++;
            $display("FAIL stall_m3: wr=%b wait=%b addr=%h want 1 1111 %h", a_wr, wait_rr, a_addr, addr_of(3));
        end
        s_wait = 1'b0;
        #1;
        n_tests++;
        if (wait_rr !== 4'b0111) begin
            n_fail++;
            $display("FAIL stall_release_wait: got %b want 0111", wait_rr);
        end
        tick();
        m_wr[3] = 1'b0;
        n_tests++;
        if ({a_wr, wait_rr} !== {1'b0, 4'hF}) begin
            n_fail++;
            $display("FAIL zero_len_done: wr=%b wait=%b want 0 1111", a_wr, wait_rr);
        end
        // master 1 drops Write mid-burst; grant must stay with it
        set_master(1, 1'b1, 1'b0, 8'd2);
        set_master(0, 1'b0, 1'b0, 8'd1);
        tick();
        tick();
        m_wr[1] = 1'b0;
        m_wr[0] = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({a_wr, wait_rr, a_addr} !== {1'b0, 4'b1101, addr_of(1)}) begin
            n_fail++;
            $display("FAIL hold_grant: wr=%b wait=%b addr=%h want 0 1101 %h", a_wr, wait_rr, a_addr, addr_of(1));
        end
        m_wr[1] = 1'b1;
        tick();
        m_wr[1] = 1'b0;
        n_tests++;
        if (wait_rr !== 4'hF) begin
            n_fail++;
            $display("FAIL hold_done_idle: wait=%b want 1111", wait_rr);
        end
        tick();
        n_tests++;
        if ({a_wr, wait_rr} !== {1'b1, 4'b1110}) begin
            n_fail++;
            $display("FAIL after_hold_m0: wr=%b wait=%b want 1 1110", a_wr, wait_rr);
        end
        tick();
        m_wr[0] = 1'b0;
    endtask

    task automatic test_reads();
        logic [NM-1:0] exp_rv;
        logic [CW-1:0] exp_pend;
        set_master(1, 1'b0, 1'b1, 8'd3);
        tick();
        n_tests++;
        if ({a_rd, a_wr, a_bc, wait_rr, a_addr} !== {2'b10, 8'd3, 4'b1101, addr_of(1)}) begin
            n_fail++;
            $display("FAIL rd_m1_cmd: rd=%b wr=%b bc=%0d wait=%b addr=%h want 1 0 3 1101 %h",
                     a_rd, a_wr, a_bc, wait_rr, a_addr, addr_of(1));
        end
        tick();
        m_rd[1] = 1'b0;
        set_master(3, 1'b0, 1'b1, 8'd2);
        n_tests++;
        if (pend_rr !== 4'd1) begin
            n_fail++;
            $display("FAIL rd_pend_first: got %0d want 1", pend_rr);
        end
        tick();
        n_tests++;
        if ({a_rd, a_bc, wait_rr} !== {1'b1, 8'd2, 4'b0111}) begin
            n_fail++;
            $display("FAIL rd_m3_cmd: rd=%b bc=%0d wait=%b want 1 2 0111", a_rd, a_bc, wait_rr);
        end
        tick();
        m_rd[3] = 1'b0;
        n_tests++;
        if (pend_rr !== 4'd2) begin
            n_fail++;
            $display("FAIL rd_pend_second: got %0d want 2", pend_rr);
        end
        for (int k = 0; k < 5; k++) begin
            s_rvalid = 1'b1;
            s_rdata  = 32'h5A00_0000 + 32'(k);
            tick();
            exp_rv   = (k < 3) ? 4'b0010 : 4'b1000;
            exp_pend = (k < 2) ? 4'd2 : (k < 4) ? 4'd1 : 4'd0;
            n_tests++;
            if ({rvalid_rr, rdata_rr, pend_rr} !== {exp_rv, 32'h5A00_0000 + 32'(k), exp_pend}) begin
                n_fail++;
                $display("FAIL rd_beat%0d: rv=%b data=%h pend=%0d want %b %h %0d",
                         k + 1, rvalid_rr, rdata_rr, pend_rr, exp_rv, 32'h5A00_0000 + 32'(k), exp_pend);
            end
        end
        s_rvalid = 1'b0;
        tick();
        n_tests++;
        if ({rvalid_rr, err_rr} !== {4'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL rd_after: rv=%b err=%b want 0000 0", rvalid_rr, err_rr);
        end
    endtask

    task automatic test_pending_full();
        set_master(0, 1'b0, 1'b1, 8'd1);
        for (int k = 1; k <= PD; k++) begin
            tick();
            tick();
            n_tests++;
            if (pend_rr !== CW'(k)) begin
                n_fail++;
                $display("FAIL full_fill%0d: pend=%0d want %0d", k, pend_rr, k);
            end
        end
        tick();
        tick();
        n_tests++;
        if ({a_rd, wait_rr, pend_rr} !== {1'b0, 4'hF, 4'd8}) begin
            n_fail++;
            $display("FAIL full_block: rd=%b wait=%b pend=%0d want 0 1111 8", a_rd, wait_rr, pend_rr);
        end
        s_rvalid = 1'b1;
        tick();
        s_rvalid = 1'b0;
        n_tests++;
        if ({rvalid_rr, pend_rr, a_rd, wait_rr} !== {4'b0001, 4'd7, 1'b1, 4'b1110}) begin
            n_fail++;
            $display("FAIL full_unblock: rv=%b pend=%0d rd=%b wait=%b want 0001 7 1 1110",
                     rvalid_rr, pend_rr, a_rd, wait_rr);
        end
        tick();
        m_rd[0] = 1'b0;
        n_tests++;
        if (pend_rr !== 4'd8) begin
            n_fail++;
            $display("FAIL full_ninth_accepted: pend=%0d want 8", pend_rr);
        end
        s_rvalid = 1'b1;
        for (int k = 0; k < PD; k++) tick();
        s_rvalid = 1'b0;
        n_tests++;
        if ({pend_rr, err_rr} !== {4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL full_drain: pend=%0d err=%b want 0 0", pend_rr, err_rr);
        end
    endtask

    task automatic test_error();
        s_rvalid = 1'b1;
        tick();
        s_rvalid = 1'b0;
        n_tests++;
        if ({rvalid_rr, err_rr, pend_rr} !== {4'h0, 1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL err_set: rv=%b err=%b pend=%0d want 0000 1 0", rvalid_rr, err_rr, pend_rr);
        end
        tick();
        tick();
        tick();
        n_tests++;
        if (err_rr !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b want 1", err_rr);
        end
    endtask

    task automatic test_fixed_priority();
        logic rr_saw1;
        rr_saw1 = 1'b0;
        s_rdata = 32'hDEAD_BEEF;
        rst_n   = 1'b0;
        tick();
        rst_n = 1'b1;
        n_tests++;
        if ({err_rr, err_fp} !== 2'b00) begin
            n_fail++;
            $display("FAIL err_cleared: rr=%b fp=%b want 0 0", err_rr, err_fp);
        end
        set_master(0, 1'b1, 1'b0, 8'd4);
        set_master(1, 1'b1, 1'b0, 8'd4);
        for (int c = 0; c < 15; c++) begin
            tick();
            if (wait_rr[1] === 1'b0) rr_saw1 = 1'b1;
            n_tests++;
            if (wait_fp[1] !== 1'b1 || (a_wr_fp === 1'b1 && a_addr_fp !== addr_of(0))) begin
                n_fail++;
                $display("FAIL fp_cycle%0d: wait=%b wr=%b addr=%h want wait[1]=1 addr %h",
                         c, wait_fp, a_wr_fp, a_addr_fp, addr_of(0));
            end
        end
        n_tests++;
        if (rr_saw1 !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_alternates: saw master1 grant=%b want 1", rr_saw1);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({a_wr_fp, wait_fp, rdata_fp} !== {1'b1, 4'b1110, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL fp_beat2: wr=%b wait=%b data=%h want 1 1110 deadbeef", a_wr_fp, wait_fp, rdata_fp);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({a_wr_fp, a_rd_fp, wait_fp, rvalid_fp, pend_fp, err_fp, rdata_fp} !==
            {2'b00, 4'hF, 4'h0, 4'd0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL fp_midburst_reset: wr=%b rd=%b wait=%b rv=%b pend=%0d err=%b data=%h want 0 0 1111 0000 0 0 0",
                     a_wr_fp, a_rd_fp, wait_fp, rvalid_fp, pend_fp, err_fp, rdata_fp);
        end
        m_wr = '0;
        tick();
        rst_n = 1'b1;
        tick();
        n_tests++;
        if ({a_wr_fp, wait_fp} !== {1'b0, 4'hF}) begin
            n_fail++;
            $display("FAIL fp_post_reset: wr=%b wait=%b want 0 1111", a_wr_fp, wait_fp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        m_addr   = '0;
        m_be     = '0;
        m_bc     = '0;
        m_wd     = '0;
        m_wr     = '0;
        m_rd     = '0;
        s_wait   = 1'b0;
        s_rvalid = 1'b0;
        s_rdata  = '0;
        test_reset();
        test_rr_write();
        test_write_stall_hold();
        test_reads();
        test_pending_full();
        test_error();
        test_fixed_priority();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/avalon_burst_arbiter.md
AVALON_BURST_ARBITER -- requirements
Module: avalon_burst_arbiter

Interface
REQ-001 SHALL have parameter NumMasters, default 4, meaning number of Avalon-MM masters (legal range 2..8).
REQ-002 SHALL have parameter DataWidth, default 256, meaning data bus width in bits.
REQ-003 SHALL have parameter AddressWidth, default 27, meaning word address width.
REQ-004 SHALL have parameter BurstWidth, default 8, meaning BurstCount width.
REQ-005 SHALL have parameter PendingDepth, default 8, meaning maximum outstanding read bursts (power of 2).
REQ-006 SHALL have parameter FixedPriority, default 0, meaning 0 = round-robin and 1 = lowest index wins.
REQ-007 SHALL have port ipClk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-008 SHALL have port ipReset  input  1  meaning asynchronous, active-low reset.
REQ-009 SHALL have port ipMaster_Address  input  NumMasters*AddressWidth  meaning per-master address, master i at slice i.
REQ-010 SHALL have port ipMaster_ByteEnable  input  NumMasters*DataWidth/8  meaning per-master byte enables.
REQ-011 SHALL have port ipMaster_BurstCount  input  NumMasters*BurstWidth  meaning per-master burst length.
REQ-012 SHALL have port ipMaster_WriteData  input  NumMasters*DataWidth  meaning per-master write data.
REQ-013 SHALL have port ipMaster_Write  input  NumMasters  meaning per-master write request.
REQ-014 SHALL have port ipMaster_Read  input  NumMasters  meaning per-master read request.
REQ-015 SHALL have port opMaster_WaitRequest  output  NumMasters  meaning per-master stall.
REQ-016 SHALL have port opMaster_ReadData  output  DataWidth  meaning registered read data, broadcast to all masters.
REQ-017 SHALL have port opMaster_ReadValid  output  NumMasters  meaning per-master read-data valid.
REQ-018 SHALL have ports ipAvalon_WaitRequest in 1, opAvalon_Address out AddressWidth, opAvalon_ByteEnable out DataWidth/8, opAvalon_BurstCount out BurstWidth, opAvalon_WriteData out DataWidth, opAvalon_Write out 1, opAvalon_Read out 1, ipAvalon_ReadData in DataWidth, ipAvalon_ReadValid in 1, meaning the slave-side Avalon-MM port.
REQ-019 SHALL have port opPendingReads  output  $clog2(PendingDepth+1)  meaning outstanding read bursts.
REQ-020 SHALL have port opError  output  1  meaning sticky flag for ReadValid received with no pending read.

Function
REQ-021 SHALL implement FSM states IDLE, WRITE_BURST, READ_CMD; grant index is registered.
REQ-022 In IDLE with any Write|Read asserted, SHALL register the winner and enter WRITE_BURST (winner's Write=1) or READ_CMD; arbitration latency is one cycle.
REQ-023 Round-robin SHALL search from (last granted+1) mod NumMasters; FixedPriority=1 SHALL choose the lowest index.
REQ-024 In IDLE, opAvalon_Write/Read SHALL be 0 and all opMaster_WaitRequest SHALL be 1.
REQ-025 In non-IDLE states, the granted master's Address/ByteEnable/BurstCount/WriteData/Write/Read SHALL be muxed combinationally to the slave port.
REQ-026 Non-granted masters' WaitRequest SHALL be 1; the granted master's WaitRequest SHALL equal ipAvalon_WaitRequest, except per REQ-029.
REQ-027 WRITE_BURST: on the first accepted beat (Write & !WaitRequest), SHALL load beat counter = BurstCount (0 treated as 1), decrement on each accepted beat, and return to IDLE after the last beat.
REQ-028 The grant SHALL be held until the burst completes even if the master deasserts Write mid-burst.
REQ-029 READ_CMD: on an accepted read, SHALL push {index, BurstCount (0 treated as 1)} into the tracker FIFO and return to IDLE; when the tracker is full, SHALL force opAvalon_Read=0 and master WaitRequest=1.
REQ-030 SHALL register ipAvalon_ReadValid/ReadData into opMaster_ReadValid[head index]/opMaster_ReadData (1-cycle latency); a remaining-beat counter SHALL pop the head on its last beat.
REQ-031 Simultaneous push and pop SHALL leave opPendingReads unchanged.
REQ-032 ReadValid with an empty tracker SHALL be dropped (no opMaster_ReadValid) and SHALL set opError until reset.

Reset
REQ-033 ipReset low SHALL immediately force IDLE, counters/tracker/opPendingReads/opError/opMaster_ReadValid/opMaster_ReadData to 0, and last-granted to NumMasters-1; reset mid-burst abandons the burst.

Verification
REQ-034 Masters 0,2 write BurstCount=4 simultaneously, round-robin -> master 0 gets 4 beats, one IDLE cycle, then master 2 gets 4 beats; master 2 WaitRequest=1 throughout master 0's burst.
REQ-035 Master 1 reads BurstCount=3 then master 3 reads BurstCount=2; slave returns 5 beats -> ReadValid[1] for beats 1-3, ReadValid[3] for beats 4-5, each one cycle after the slave; opPendingReads goes 1,2,1,0.
REQ-036 PendingDepth=8 reads issued with no return -> the ninth read sees WaitRequest=1 and opAvalon_Read=0; one returned burst then accepts it.
REQ-037 ReadValid with opPendingReads=0 -> no opMaster_ReadValid, opError=1 and held.
REQ-038 FixedPriority=1, masters 0 and 1 both requesting continuously -> master 1 never granted; ipReset low during beat 2 of 4 -> all outputs at reset values within the same cycle.
